// File: rtl/halt_drain_dump_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | halt_drain_dump_pkg                                                |
// | Shared constants, FSM encoding and width helper for the dump block.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package halt_drain_dump_pkg;

    localparam logic [31:0] C_HALT_INSTR   = 32'hFFFF_FFFF;
    localparam int          C_DRAIN_CYCLES = 5;
    localparam int          C_DUMP_WORDS   = 50;
    localparam int          C_ADDR_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/halt_drain_dump_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | halt_drain_dump_if                                                 |
// | CPU-side, memory-read and dump-stream signals of the dump block.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface halt_drain_dump_if
    import halt_drain_dump_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W
) ();

    logic [31:0]       instr_D;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_data;
    logic              cpu_freeze;
    logic              dump_valid;
    logic              dump_ready;
    logic [31:0]       dump_data;
    logic [ADDR_W-1:0] dump_index;
    logic              done;

    modport master (
        input  instr_D, mem_rd_data, dump_ready,
        output mem_rd_addr, cpu_freeze, dump_valid, dump_data, dump_index, done
    );

    modport slave (
        output instr_D, mem_rd_data, dump_ready,
        input  mem_rd_addr, cpu_freeze, dump_valid, dump_data, dump_index, done
    );

endinterface
`default_nettype wire

// File: rtl/halt_drain_dump_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | halt_drain_dump_counter                                            |
// | Clear/load/increment counter with terminal-count flag, no wrap.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module halt_drain_dump_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_inc,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_tc
);

    logic [WIDTH-1:0] r_count;

    assign o_tc    = (r_count == WIDTH'(TERMINAL));
    assign o_count = r_count;

    // Increment saturates at TERMINAL so the count can never wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/halt_drain_dump.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | halt_drain_dump                                                    |
// | Detects halt in ID, drains stores, freezes CPU, streams memory out.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module halt_drain_dump
    import halt_drain_dump_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR   = C_HALT_INSTR,
    parameter int          DRAIN_CYCLES = C_DRAIN_CYCLES,
    parameter int          DUMP_WORDS   = C_DUMP_WORDS,
    parameter int          ADDR_W       = C_ADDR_W
) (
    input  wire logic      CLK,
    input  wire logic      RESET,
    halt_drain_dump_if.master hdd
);

    localparam int DRAIN_W = clog2_min1(DRAIN_CYCLES);
    localparam int IDX_W   = clog2_min1(DUMP_WORDS);

    generate
        if (DUMP_WORDS < 1) begin : g_bad_dump_words
            $error("halt_drain_dump: DUMP_WORDS must be >= 1");
        end
        if (DRAIN_CYCLES < 1) begin : g_bad_drain_cycles
            $error("halt_drain_dump: DRAIN_CYCLES must be >= 1");
        end
        if (IDX_W > ADDR_W) begin : g_bad_addr_w
            $error("halt_drain_dump: ADDR_W too narrow for DUMP_WORDS");
        end
    endgenerate

    state_t r_state;
    state_t w_state_nxt;

    logic               w_drain_clr;
    logic               w_drain_inc;
    logic               w_drain_tc;
    logic [DRAIN_W-1:0] w_unused_drain_cnt;
    logic               w_idx_clr;
    logic               w_idx_inc;
    logic               w_idx_tc;
    logic [IDX_W-1:0]   w_idx_cnt;
    logic               w_handshake;

    logic               r_cpu_freeze;
    logic               r_dump_valid;
    logic [31:0]        r_dump_data;
    logic [ADDR_W-1:0]  r_dump_index;
    logic               r_done;

    halt_drain_dump_counter #(
        .WIDTH    (DRAIN_W),
        .TERMINAL (DRAIN_CYCLES - 1)
    ) u_drain_cnt (
        .clk        (CLK),
        .rst        (RESET),
        .i_clear    (w_drain_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_drain_inc),
        .o_count    (w_unused_drain_cnt),
        .o_tc       (w_drain_tc)
    );

    halt_drain_dump_counter #(
        .WIDTH    (IDX_W),
        .TERMINAL (DUMP_WORDS - 1)
    ) u_idx_cnt (
        .clk        (CLK),
        .rst        (RESET),
        .i_clear    (w_idx_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_idx_inc),
        .o_count    (w_idx_cnt),
        .o_tc       (w_idx_tc)
    );

    assign w_handshake = (r_state == ST_HOLD) && r_dump_valid && hdd.dump_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_clr = 1'b0;
        w_drain_inc = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Case equality keeps an unknown instruction word from halting.
                if (hdd.instr_D === HALT_INSTR) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_clr = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_drain_tc) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_clr   = 1'b1;
                end else begin
                    w_drain_inc = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    if (w_idx_tc) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_LOAD;
                        w_idx_inc   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Freeze/done follow the next state so they are valid in the first cycle of LOAD/DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cpu_freeze <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= '0;
            r_dump_index <= '0;
            r_done       <= 1'b0;
        end else begin
            r_cpu_freeze <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DRAIN);
            r_done       <= (w_state_nxt == ST_DONE);
            if (r_state == ST_LOAD) begin
                r_dump_valid <= 1'b1;
                r_dump_data  <= hdd.mem_rd_data;
                r_dump_index <= ADDR_W'(w_idx_cnt);
            end else if (w_handshake) begin
                r_dump_valid <= 1'b0;
            end
        end
    end

    assign hdd.mem_rd_addr = ADDR_W'(w_idx_cnt);
    assign hdd.cpu_freeze  = r_cpu_freeze;
    assign hdd.dump_valid  = r_dump_valid;
    assign hdd.dump_data   = r_dump_data;
    assign hdd.dump_index  = r_dump_index;
    assign hdd.done        = r_done;

endmodule
`default_nettype wire
